// File: rtl/clock_pkg.sv
// Shared BCD time types and helpers for the digital clock.
// Used by the time counter, display and alarm blocks.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_00 = 8'h00;
  localparam bcd2_t BCD_01 = 8'h01;
  localparam bcd2_t BCD_11 = 8'h11;
  localparam bcd2_t BCD_12 = 8'h12;
  localparam bcd2_t BCD_23 = 8'h23;
  localparam bcd2_t BCD_59 = 8'h59;

  // both digits decimal and value not above max
  function automatic logic bcd_valid(
    input bcd2_t v,
    input bcd2_t max
  );
    return (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) &&
           (v <= max);
  endfunction

  // +1 with decimal carry from units to tens
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, 00..MAX_BCD.
// wrap flags that an enabled count rolls over this cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX_BCD = BCD_59
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  clr,
  input  logic  load,
  input  bcd2_t d,
  output bcd2_t q,
  output logic  wrap
);

  assign wrap = en && (q == MAX_BCD);

  // count register: rst > load > clr > en
  always_ff @(posedge clk) begin
    if (rst)
      q <= BCD_00;
    else if (load)
      q <= d;
    else if (clr)
      q <= BCD_00;
    else if (en)
      q <= wrap ? BCD_00 : bcd_inc(q);
  end

endmodule

// File: rtl/time_counter_bcd.sv
// HH:MM:SS BCD time-of-day counter with load,
// set buttons and carry/rollover pulses.
module time_counter_bcd
  import clock_pkg::*;
#(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  input  logic       ld_pm,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       min_carry,
  output logic       hr_carry,
  output logic       day_wrap,
  output logic       load_err
);

  logic  hh_ok;
  logic  ld_valid;
  logic  ld_ok;
  logic  inc_go;
  logic  inc_min_go;
  logic  inc_hr_go;
  logic  tick_go;
  logic  ss_wrap;
  logic  mm_wrap;
  logic  mm_en;
  logic  hr_tick;
  logic  hr_step;
  bcd2_t hh_nxt;
  logic  pm_nxt;
  logic  day_evt;

  // 12h mode has no hour 00
  assign hh_ok = H24 ?
    bcd_valid(ld_hh, BCD_23) :
    (bcd_valid(ld_hh, BCD_12) &&
     (ld_hh != BCD_00));

  assign ld_valid = hh_ok &&
    bcd_valid(ld_mm, BCD_59) &&
    bcd_valid(ld_ss, BCD_59);

  // a load, valid or not, swallows set and tick
  assign ld_ok      = load && ld_valid;
  assign inc_go     = !load && (inc_min || inc_hr);
  assign inc_min_go = !load && inc_min;
  assign inc_hr_go  = !load && inc_hr;
  assign tick_go    = !load && !inc_go && tick;

  assign mm_en   = inc_min_go || (tick_go && ss_wrap);
  assign hr_tick = tick_go && ss_wrap && mm_wrap;
  assign hr_step = inc_hr_go || hr_tick;

  bcd_mod_counter #(
    .MAX_BCD (BCD_59)
  ) u_ss (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_go),
    .clr  (inc_min_go),
    .load (ld_ok),
    .d    (ld_ss),
    .q    (ss),
    .wrap (ss_wrap)
  );

  bcd_mod_counter #(
    .MAX_BCD (BCD_59)
  ) u_mm (
    .clk  (clk),
    .rst  (rst),
    .en   (mm_en),
    .clr  (1'b0),
    .load (ld_ok),
    .d    (ld_mm),
    .q    (mm),
    .wrap (mm_wrap)
  );

  // next hour and pm under 12/24 rules
  always_comb begin
    hh_nxt  = bcd_inc(hh);
    pm_nxt  = pm;
    day_evt = 1'b0;
    if (H24) begin
      if (hh == BCD_23) begin
        hh_nxt  = BCD_00;
        day_evt = 1'b1;
      end
    end else begin
      unique case (1'b1)
        (hh == BCD_12): hh_nxt = BCD_01;
        (hh == BCD_11): begin
          hh_nxt  = BCD_12;
          pm_nxt  = ~pm;
          day_evt = pm;
        end
        default: ;
      endcase
    end
  end

  // hours and pm register
  always_ff @(posedge clk) begin
    if (rst) begin
      hh <= H24 ? BCD_00 : BCD_12;
      pm <= 1'b0;
    end else if (ld_ok) begin
      hh <= ld_hh;
      pm <= H24 ? 1'b0 : ld_pm;
    end else if (hr_step) begin
      hh <= hh_nxt;
      pm <= pm_nxt;
    end
  end

  // one-cycle event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      min_carry <= 1'b0;
      hr_carry  <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_carry <= tick_go && ss_wrap;
      hr_carry  <= hr_tick;
      day_wrap  <= hr_tick && day_evt;
      load_err  <= load && !ld_valid;
    end
  end

endmodule

// File: tb/tb_time_counter_bcd.sv
// Randomized bench for time_counter_bcd, both hour modes,
// against a seconds-of-day reference model.
module tb_time_counter_bcd;

  localparam int DAY = 86400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, load, ld_pm;
  logic       inc_min, inc_hr;
  logic [7:0] ld_hh, ld_mm, ld_ss;

  logic [7:0] hh24, mm24, ss24;
  logic       pm24, mc24, hc24, dw24, le24;
  logic [7:0] hh12, mm12, ss12;
  logic       pm12, mc12, hc12, dw12, le12;

  time_counter_bcd #(.H24(1'b1)) u24 (
    .clk(clk), .rst(rst), .tick(tick),
    .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm),
    .ld_ss(ld_ss), .ld_pm(ld_pm),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .hh(hh24), .mm(mm24), .ss(ss24), .pm(pm24),
    .min_carry(mc24), .hr_carry(hc24),
    .day_wrap(dw24), .load_err(le24)
  );

  time_counter_bcd #(.H24(1'b0)) u12 (
    .clk(clk), .rst(rst), .tick(tick),
    .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm),
    .ld_ss(ld_ss), .ld_pm(ld_pm),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .hh(hh12), .mm(mm12), .ss(ss12), .pm(pm12),
    .min_carry(mc12), .hr_carry(hc12),
    .day_wrap(dw12), .load_err(le12)
  );

  logic [28:0] g24, g12, e24, e12;
  assign g24 = {hh24, mm24, ss24, pm24,
                mc24, hc24, dw24, le24};
  assign g12 = {hh12, mm12, ss12, pm12,
                mc12, hc12, dw12, le12};

  int checks = 0;
  int errors = 0;
  int sod24 = 0;
  int sod12 = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit nib_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // time kept as seconds since midnight; 12h view derived from it
  task automatic model_apply(
    input  bit          is12,
    inout  int          sod,
    output logic [28:0] e
  );
    int h, m, s, dh;
    bit mc, hc, dw, le, ok;
    mc = 0; hc = 0; dw = 0; le = 0;
    h = sod / 3600;
    m = (sod / 60) % 60;
    s = sod % 60;
    if (rst) begin
      sod = 0;
    end else if (load) begin
      ok = nib_ok(ld_hh) && nib_ok(ld_mm) &&
           nib_ok(ld_ss) && dec(ld_mm) < 60 &&
           dec(ld_ss) < 60;
      if (is12)
        ok = ok && dec(ld_hh) >= 1 && dec(ld_hh) <= 12;
      else
        ok = ok && dec(ld_hh) <= 23;
      if (ok) begin
        h = dec(ld_hh);
        if (is12) h = h % 12 + (ld_pm ? 12 : 0);
        sod = h * 3600 + dec(ld_mm) * 60 + dec(ld_ss);
      end else begin
        le = 1;
      end
    end else if (inc_min || inc_hr) begin
      if (inc_min) begin
        m = (m + 1) % 60;
        s = 0;
      end
      if (inc_hr) h = (h + 1) % 24;
      sod = h * 3600 + m * 60 + s;
    end else if (tick) begin
      sod = (sod + 1) % DAY;
      mc = (sod % 60) == 0;
      hc = (sod % 3600) == 0;
      dw = (sod == 0);
    end
    h = sod / 3600;
    m = (sod / 60) % 60;
    s = sod % 60;
    dh = is12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    e = {to_bcd(dh), to_bcd(m), to_bcd(s),
         is12 && (h >= 12), mc, hc, dw, le};
  endtask

  task automatic idle();
    rst = 0; tick = 0; load = 0; ld_pm = 0;
    inc_min = 0; inc_hr = 0;
    ld_hh = 0; ld_mm = 0; ld_ss = 0;
  endtask

  task automatic set_load(
    input logic [7:0] h,
    input logic [7:0] m,
    input logic [7:0] s,
    input logic       p
  );
    load = 1; ld_hh = h; ld_mm = m;
    ld_ss = s; ld_pm = p;
  endtask

  // advance one clock with the model, sample 1ns after the edge
  task automatic clk_step();
    model_apply(1'b0, sod24, e24);
    model_apply(1'b1, sod12, e12);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; tick = 1;
    set_load(8'h05, 8'h06, 8'h07, 1'b1);
    clk_step();
    checks++;
    if ({g24, g12} !== {e24, e12} ||
        g24 !== 29'h0 ||
        g12[28:21] !== 8'h12) begin
      errors++;
      $display("FAIL reset got24=%h exp24=%h got12=%h exp12=%h",
               g24, e24, g12, e12);
    end
    idle();
  endtask

  task automatic test_min_carry();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) set_load(8'h00, 8'h00, 8'h58, 1'b0);
      else if (i < 3) tick = 1;
      clk_step();
      checks++;
      if ({g24, g12} !== {e24, e12} ||
          mc24 !== (i == 2)) begin
        errors++;
        $display("FAIL min_carry[%0d] got24=%h exp24=%h got12=%h exp12=%h",
                 i, g24, e24, g12, e12);
      end
    end
    idle();
  endtask

  task automatic test_day_wrap();
    logic [7:0] lh [6];
    logic       lp [6];
    lh = '{8'h23, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00};
    lp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i % 2 == 0)
        set_load(lh[i], 8'h59, 8'h59, lp[i]);
      else
        tick = 1;
      clk_step();
      checks++;
      if ({g24, g12} !== {e24, e12}) begin
        errors++;
        $display("FAIL day_wrap[%0d] got24=%h exp24=%h got12=%h exp12=%h",
                 i, g24, e24, g12, e12);
      end
    end
    idle();
  endtask

  task automatic test_load_err();
    logic [7:0] bh [4];
    logic [7:0] bm [4];
    bh = '{8'h10, 8'h24, 8'h00, 8'h1A};
    bm = '{8'h6A, 8'h20, 8'h20, 8'h20};
    idle();
    set_load(8'h10, 8'h20, 8'h30, 1'b0);
    clk_step();
    for (int i = 0; i < 4; i++) begin
      idle();
      tick = 1;
      set_load(bh[i], bm[i], 8'h00, 1'b1);
      clk_step();
      checks++;
      if ({g24, g12} !== {e24, e12}) begin
        errors++;
        $display("FAIL load_err[%0d] got24=%h exp24=%h got12=%h exp12=%h",
                 i, g24, e24, g12, e12);
      end
    end
    idle();
  endtask

  task automatic test_inc();
    idle();
    set_load(8'h10, 8'h59, 8'h30, 1'b0);
    clk_step();
    idle();
    inc_min = 1; tick = 1;
    clk_step();
    checks++;
    if ({g24, g12} !== {e24, e12} ||
        {hh24, mm24, ss24} !== 24'h100000) begin
      errors++;
      $display("FAIL inc_min got24=%h exp24=%h got12=%h exp12=%h",
               g24, e24, g12, e12);
    end
    idle();
    set_load(8'h23, 8'h15, 8'h20, 1'b0);
    clk_step();
    for (int i = 0; i < 3; i++) begin
      idle();
      inc_hr = 1;
      inc_min = (i == 2);
      clk_step();
      checks++;
      if ({g24, g12} !== {e24, e12}) begin
        errors++;
        $display("FAIL inc_hr[%0d] got24=%h exp24=%h got12=%h exp12=%h",
                 i, g24, e24, g12, e12);
      end
    end
    idle();
  endtask

  task automatic test_mid_rst();
    idle();
    set_load(8'h09, 8'h30, 8'h15, 1'b1);
    clk_step();
    for (int i = 0; i < 3; i++) begin
      idle();
      tick = 1;
      clk_step();
    end
    idle();
    rst = 1; tick = 1;
    set_load(8'h08, 8'h08, 8'h08, 1'b1);
    clk_step();
    checks++;
    if ({g24, g12} !== {e24, e12} ||
        g24 !== 29'h0) begin
      errors++;
      $display("FAIL mid_rst got24=%h exp24=%h got12=%h exp12=%h",
               g24, e24, g12, e12);
    end
    idle();
  endtask

  task automatic test_random();
    int r, k;
    for (int n = 0; n < 4000; n++) begin
      idle();
      r = $urandom_range(0, 199);
      k = $urandom_range(0, 7);
      if (r == 0) begin
        rst = 1;
        tick = 1;
      end else if (r < 10) begin
        if (k == 0)
          set_load(8'($urandom), 8'($urandom),
                   8'($urandom), 1'($urandom));
        else
          set_load(
            (k > 5) ? to_bcd($urandom_range(10, 12)) :
                      to_bcd($urandom_range(0, 23)),
            (k < 5) ? 8'h59 : to_bcd($urandom_range(0, 59)),
            to_bcd($urandom_range(40, 59)),
            1'($urandom));
      end else if (r < 18) begin
        inc_min = (k % 2) == 1;
        inc_hr  = (k % 2) == 0 || k > 5;
        tick    = 1'($urandom);
      end else begin
        tick = ($urandom_range(0, 9) != 0);
      end
      clk_step();
      checks++;
      if ({g24, g12} !== {e24, e12}) begin
        errors++;
        $display("FAIL random[%0d] got24=%h exp24=%h got12=%h exp12=%h",
                 n, g24, e24, g12, e12);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_min_carry();
    test_day_wrap();
    test_load_err();
    test_inc();
    test_mid_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
